// File: rtl/fmac_issue_ctrl_pkg.sv
// Shared definitions for the fmac issue controller: rounding-mode codes, flag bit positions, FSM states.
package fmac_issue_ctrl_pkg;

   localparam logic [1:0] C_RM_RNE = 2'd0;
   localparam logic [1:0] C_RM_RTZ = 2'd1;
   localparam logic [1:0] C_RM_RDN = 2'd2;
   localparam logic [1:0] C_RM_RUP = 2'd3;

   localparam int unsigned C_FLAG_OF = 2;
   localparam int unsigned C_FLAG_UF = 1;
   localparam int unsigned C_FLAG_NX = 0;
   localparam int unsigned C_FLAG_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } issue_state_e;

endpackage

// File: rtl/fmac_issue_ctrl_res_fifo.sv
// Result FIFO: C_DEPTH entries of C_W bits, wrap-bit pointers, head visible combinationally.
module fmac_res_fifo #(
   parameter int unsigned C_DEPTH = 2,
   parameter int unsigned C_W     = 40
) (
   input  logic           Clk_CI,
   input  logic           Rst_RBI,
   input  logic           Push_SI,
   input  logic [C_W-1:0] Push_DI,
   input  logic           Pop_SI,
   output logic           Full_SO,
   output logic           Empty_SO,
   output logic [C_W-1:0] Head_DO
);
   localparam int unsigned C_AW = $clog2(C_DEPTH);

   logic [C_AW:0]  wptr_q, rptr_q;
   logic [C_W-1:0] mem_q [C_DEPTH];
   logic           do_push, do_pop;

   assign Empty_SO = (wptr_q == rptr_q);
   assign Full_SO  = (wptr_q[C_AW] != rptr_q[C_AW]) && (wptr_q[C_AW-1:0] == rptr_q[C_AW-1:0]);
   assign Head_DO  = mem_q[rptr_q[C_AW-1:0]];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = Pop_SI && !Empty_SO;
   assign do_push = Push_SI && (!Full_SO || do_pop);

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < C_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wptr_q[C_AW-1:0]] <= Push_DI;
            wptr_q                  <= wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fmac_issue_ctrl.sv
// Drives registered operands to an external combinational fmac, holds them C_LAT cycles, then
// captures result/tag/{OF,UF,NX} into an output FIFO; accumulates sticky exception flags.
module fmac_issue_ctrl
   import fmac_issue_ctrl_pkg::*;
#(
   parameter int unsigned C_OP    = 32,
   parameter int unsigned C_RM    = 2,
   parameter int unsigned C_TAG   = 5,
   parameter int unsigned C_LAT   = 3,
   parameter int unsigned C_DEPTH = 2
) (
   input  logic                Clk_CI,
   input  logic                Rst_RBI,
   input  logic                In_Valid_SI,
   output logic                In_Ready_SO,
   input  logic [C_OP-1:0]     Op_a_DI,
   input  logic [C_OP-1:0]     Op_b_DI,
   input  logic [C_OP-1:0]     Op_c_DI,
   input  logic [C_RM-1:0]     RM_SI,
   input  logic [C_TAG-1:0]    Tag_DI,
   output logic [C_OP-1:0]     Fmac_a_DO,
   output logic [C_OP-1:0]     Fmac_b_DO,
   output logic [C_OP-1:0]     Fmac_c_DO,
   output logic [C_RM-1:0]     Fmac_RM_SO,
   input  logic [C_OP-1:0]     Fmac_Res_DI,
   input  logic                Fmac_OF_SI,
   input  logic                Fmac_UF_SI,
   input  logic                Fmac_NX_SI,
   output logic                Out_Valid_SO,
   input  logic                Out_Ready_SI,
   output logic [C_OP-1:0]     Res_DO,
   output logic [C_TAG-1:0]    Tag_DO,
   output logic [C_FLAG_W-1:0] Flags_DO,
   output logic [C_FLAG_W-1:0] Sticky_DO,
   input  logic                Sticky_clr_SI
);
   localparam int unsigned C_ENT      = C_OP + C_TAG + C_FLAG_W;
   localparam logic [3:0]  C_CNT_INIT = 4'(C_LAT - 1);

   issue_state_e        state_q;
   logic [3:0]          cnt_q;
   logic [C_OP-1:0]     a_q, b_q, c_q;
   logic [C_RM-1:0]     rm_q;
   logic [C_TAG-1:0]    tag_q;
   logic [C_FLAG_W-1:0] sticky_q, sticky_d, push_flags;
   logic                fifo_full, fifo_empty;
   logic                accept, push, pop;
   logic [C_ENT-1:0]    head;

   // Ready uses the registered FIFO state only; an accepted op therefore always finds a free slot.
   assign In_Ready_SO  = (state_q == IDLE) && !fifo_full;
   assign accept       = In_Valid_SI && In_Ready_SO;
   assign push         = (state_q == BUSY) && (cnt_q == '0);
   assign Out_Valid_SO = !fifo_empty;
   assign pop          = Out_Valid_SO && Out_Ready_SI;

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         rm_q    <= '0;
         tag_q   <= '0;
      end else if (state_q == IDLE) begin
         if (accept) begin
            a_q     <= Op_a_DI;
            b_q     <= Op_b_DI;
            c_q     <= Op_c_DI;
            rm_q    <= RM_SI;
            tag_q   <= Tag_DI;
            cnt_q   <= C_CNT_INIT;
            state_q <= BUSY;
         end
      end else begin
         if (cnt_q == '0) begin
            state_q <= IDLE;
         end else begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   always_comb begin
      push_flags            = '0;
      push_flags[C_FLAG_OF] = Fmac_OF_SI;
      push_flags[C_FLAG_UF] = Fmac_UF_SI;
      push_flags[C_FLAG_NX] = Fmac_NX_SI;
   end

   // A clear coinciding with a retirement keeps that retirement's flags.
   always_comb begin
      sticky_d = Sticky_clr_SI ? '0 : sticky_q;
      if (push) begin
         sticky_d = sticky_d | push_flags;
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   fmac_res_fifo #(
      .C_DEPTH (C_DEPTH),
      .C_W     (C_ENT)
   ) i_res_fifo (
      .Clk_CI   (Clk_CI),
      .Rst_RBI  (Rst_RBI),
      .Push_SI  (push),
      .Push_DI  ({Fmac_Res_DI, tag_q, push_flags}),
      .Pop_SI   (pop),
      .Full_SO  (fifo_full),
      .Empty_SO (fifo_empty),
      .Head_DO  (head)
   );

   assign {Res_DO, Tag_DO, Flags_DO} = head;
   assign Fmac_a_DO  = a_q;
   assign Fmac_b_DO  = b_q;
   assign Fmac_c_DO  = c_q;
   assign Fmac_RM_SO = rm_q;
   assign Sticky_DO  = sticky_q;

endmodule

// File: tb/tb_fmac_issue_ctrl.sv
// Bench for fmac_issue_ctrl: stand-in fmac, scoreboard queue fed at acceptance, monitor on result port.
module tb_fmac_issue_ctrl;
   localparam int LAT = 3;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  tag;
      logic [2:0]  flags;
   } exp_t;

   logic        clk, rst_n;
   logic        in_vld, in_rdy, out_vld, out_rdy, sticky_clr;
   logic [31:0] op_a, op_b, op_c, f_a, f_b, f_c, f_res, res;
   logic [1:0]  rm, f_rm;
   logic [4:0]  tag_in, tag_out;
   logic        f_of, f_uf, f_nx;
   logic [2:0]  flags, sticky;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   ordy_mode = 1;
   logic [2:0] tb_sticky = 3'b000;
   exp_t exp_q[$];

   // Stand-in fmac: overflow when the biased exponent sum exceeds range (OF+NX), underflow when it
   // falls to zero or below (UF only); otherwise an integer a+b*c salted with the rounding mode.
   function automatic logic [34:0] fmac_ref(input logic [31:0] a, b, c, input logic [1:0] m);
      int          es = int'(b[30:23]) + int'(c[30:23]);
      logic        of = (es >= 382);
      logic        uf = !of && (es <= 127);
      logic [31:0] r  = of ? 32'h7F800000 : (uf ? 32'h0 : ((a + b * c) ^ {30'b0, m}));
      return {r, of, uf, of};
   endfunction

   assign {f_res, f_of, f_uf, f_nx} = fmac_ref(f_a, f_b, f_c, f_rm);

   fmac_issue_ctrl #(
      .C_OP(32), .C_RM(2), .C_TAG(5), .C_LAT(LAT), .C_DEPTH(2)
   ) dut (
      .Clk_CI(clk), .Rst_RBI(rst_n),
      .In_Valid_SI(in_vld), .In_Ready_SO(in_rdy),
      .Op_a_DI(op_a), .Op_b_DI(op_b), .Op_c_DI(op_c), .RM_SI(rm), .Tag_DI(tag_in),
      .Fmac_a_DO(f_a), .Fmac_b_DO(f_b), .Fmac_c_DO(f_c), .Fmac_RM_SO(f_rm),
      .Fmac_Res_DI(f_res), .Fmac_OF_SI(f_of), .Fmac_UF_SI(f_uf), .Fmac_NX_SI(f_nx),
      .Out_Valid_SO(out_vld), .Out_Ready_SI(out_rdy),
      .Res_DO(res), .Tag_DO(tag_out), .Flags_DO(flags),
      .Sticky_DO(sticky), .Sticky_clr_SI(sticky_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, " in_rdy"}, in_rdy, 1);
      check({pfx, " out_vld"}, out_vld, 0);
      check({pfx, " fmac_abc"}, {f_a, f_b}, 0);
      check({pfx, " fmac_c_rm"}, {f_c, f_rm}, 0);
      check({pfx, " res_tag_flags"}, {res, tag_out, flags}, 0);
      check({pfx, " sticky"}, sticky, 0);
   endtask

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic issue(input logic [31:0] a, b, c, input logic [1:0] m, input logic [4:0] t,
                        output int acc_cyc);
      exp_t        e;
      logic [34:0] r;
      int          w = 0;
      in_vld = 1'b1; op_a = a; op_b = b; op_c = c; rm = m; tag_in = t;
      while (!in_rdy && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!in_rdy) begin
         check("accept timeout in_rdy", in_rdy, 1);
         in_vld  = 1'b0;
         acc_cyc = -1;
         return;
      end
      r       = fmac_ref(a, b, c, m);
      e.res   = r[34:3];
      e.tag   = t;
      e.flags = r[2:0];
      exp_q.push_back(e);
      tb_sticky |= e.flags;
      acc_cyc = cyc;
      @(negedge clk);
      in_vld = 1'b0;
      op_a = $urandom; op_b = $urandom; op_c = $urandom;
      rm = 2'($urandom); tag_in = 5'($urandom);
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((exp_q.size() != 0 || out_vld) && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("drain pending", exp_q.size(), 0);
      @(negedge clk);
   endtask

   // Monitor: drives Out_Ready, pops the scoreboard on each handshake, checks hold-while-stalled.
   initial begin : monitor
      exp_t        e;
      logic        stalled = 1'b0;
      logic [31:0] h_res = '0;
      logic [4:0]  h_tag = '0;
      logic [2:0]  h_flags = '0;
      out_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            out_rdy = 1'b0;
         end else begin
            if (stalled) begin
               check("stall valid held", out_vld, 1);
               check("stall data held", {res, tag_out, flags}, {h_res, h_tag, h_flags});
            end
            case (ordy_mode)
               0:       out_rdy = 1'b0;
               1:       out_rdy = 1'b1;
               default: out_rdy = 1'($urandom_range(0, 1));
            endcase
            if (out_vld && out_rdy) begin
               if (exp_q.size() == 0) begin
                  check("unexpected result", out_vld, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("result tag", tag_out, e.tag);
                  check("result res", res, e.res);
                  check("result flags", flags, e.flags);
               end
               stalled = 1'b0;
            end else if (out_vld) begin
               stalled = 1'b1;
               h_res = res; h_tag = tag_out; h_flags = flags;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int t, prev;
      logic [31:0] ea, eb, ec;
      rst_n = 1'b0; in_vld = 1'b0; sticky_clr = 1'b0;
      op_a = '0; op_b = '0; op_c = '0; rm = '0; tag_in = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single op: operands held LAT cycles, result visible LAT+1 cycles after the accept cycle.
      ea = 32'h3F800000; eb = 32'h40000000; ec = 32'h40400000;
      issue(ea, eb, ec, 2'd0, 5'd3, t);
      for (int k = 1; k <= LAT; k++) begin
         check("single op fmac a/b", {f_a, f_b}, {ea, eb});
         check("single op fmac c/rm", {f_c, f_rm}, {ec, 2'd0});
         check("single op early valid", out_vld, 0);
         @(negedge clk);
      end
      check("single op valid at LAT+1", out_vld, 1);
      check("single op tag/flags", {tag_out, flags}, {5'd3, 3'b000});
      wait_drain();

      // Stall: two accepts fill the FIFO, the third waits until the consumer drains.
      ordy_mode = 0;
      @(negedge clk);
      issue($urandom, 32'h40000000, 32'h40400000, 2'd1, 5'd0, t);
      issue($urandom, 32'h41000000, 32'h3F000000, 2'd2, 5'd1, t);
      repeat (LAT) @(negedge clk);
      check("stall in_rdy low when full", in_rdy, 0);
      repeat (5) @(negedge clk);
      check("stall in_rdy still low", in_rdy, 0);
      check("stall head tag", {out_vld, tag_out}, {1'b1, 5'd0});
      ordy_mode = 1;
      issue($urandom, 32'h3F800000, 32'h3F800000, 2'd3, 5'd2, t);
      wait_drain();

      // Streaming: one accept every LAT+1 cycles with the consumer always ready.
      prev = -1;
      for (int i = 0; i < 6; i++) begin
         issue($urandom, 32'h40000000 | 32'($urandom_range(0, 255)), 32'h3F800000, 2'($urandom), 5'(8 + i), t);
         if (prev >= 0) check("stream accept interval", t - prev, LAT + 1);
         prev = t;
      end
      wait_drain();

      // Overflow, then sticky clear.
      issue(32'h0, 32'h7F000000, 32'h7F000000, 2'd0, 5'd20, t);
      wait_drain();
      check("overflow sticky", sticky, 3'b101);
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      check("sticky after clear", sticky, 3'b000);
      tb_sticky = 3'b000;

      // Clear coinciding with an underflow retirement keeps only the underflow.
      issue(32'h0, 32'h7F000000, 32'h7F000000, 2'd0, 5'd21, t);
      wait_drain();
      check("sticky before coincident clear", sticky, 3'b101);
      issue(32'h1234, 32'h00800000, 32'h00800000, 2'd0, 5'd22, t);
      repeat (LAT - 1) @(negedge clk);
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      check("sticky clear+UF push", sticky, 3'b010);
      wait_drain();

      // Reset while BUSY with one cycle left: op is dropped, nothing emitted afterwards.
      issue(32'hDEAD0001, 32'h40000000, 32'h40000000, 2'd3, 5'd30, t);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("busy reset");
      exp_q.delete();
      tb_sticky = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("no result after reset", out_vld, 0);
      end

      // Randomized traffic with a random consumer.
      ordy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue($urandom, $urandom, $urandom, 2'($urandom), 5'(i), t);
      end
      ordy_mode = 1;
      wait_drain();
      check("random sticky", sticky, tb_sticky);
      check("random no leftover", out_vld, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
